// File: rtl/formant_dp_sched.sv
// Per-bin DP sequencer for formant segmentation: walks rows k, issues E/F
// reads, min-reduces F(k-1,j)+E(j+1,i) over j and writes F(k,i)/B(k,i).
module formant_dp_sched #(
   parameter int BIT_WIDTH = 32,
   parameter int I         = 160,
   parameter int FORMANTS  = 4,
   parameter int READ_LAT  = 2,
   localparam int I_WIDTH  = $clog2(I),
   localparam int KW       = (FORMANTS > 1) ? $clog2(FORMANTS) : 1
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 begin_iter,
   input  logic [I_WIDTH-1:0]   i,
   input  logic [BIT_WIDTH-1:0] e_head,
   input  logic [BIT_WIDTH-1:0] e_prev,
   input  logic [BIT_WIDTH-1:0] f_prev,
   output logic [KW-1:0]        k_req,
   output logic [I_WIDTH-1:0]   j_req,
   output logic [KW-1:0]        k_write,
   output logic [BIT_WIDTH-1:0] f_data,
   output logic [I_WIDTH-1:0]   b_data,
   output logic                 output_valid,
   output logic                 iter_done,
   output logic                 busy
);

   typedef enum logic [2:0] {IDLE, ROW0, ISSUE, DRAIN, WRITE, DONE} state_t;

   state_t               state_q, state_d;
   logic [I_WIDTH-1:0]   i_q, i_d;
   logic [KW-1:0]        k_q, k_d;
   logic [BIT_WIDTH-1:0] min_q, min_d;
   logic [I_WIDTH-1:0]   arg_q, arg_d;
   logic [I_WIDTH-1:0]   rj_q, rj_d;
   logic [READ_LAT-1:0]  vld_q, vld_d;
   logic [READ_LAT-1:0]  last_q, last_d;
   logic [KW-1:0]        k_req_q, k_req_d;
   logic [I_WIDTH-1:0]   j_req_q, j_req_d;
   logic [KW-1:0]        k_write_q, k_write_d;
   logic [BIT_WIDTH-1:0] f_data_q, f_data_d;
   logic [I_WIDTH-1:0]   b_data_q, b_data_d;
   logic                 ov_q, ov_d;
   logic                 done_q, done_d;
   logic                 busy_q, busy_d;

   logic [BIT_WIDTH:0]   sum_w;
   logic [BIT_WIDTH-1:0] sum_sat;
   logic                 resp;
   logic [BIT_WIDTH-1:0] min_n;
   logic [I_WIDTH-1:0]   arg_n;
   logic                 go_row;
   logic [KW-1:0]        kn;

   assign sum_w   = {1'b0, f_prev} + {1'b0, e_prev};
   assign sum_sat = sum_w[BIT_WIDTH] ? '1 : sum_w[BIT_WIDTH-1:0];
   assign resp    = vld_q[READ_LAT-1];

   always_comb begin
      state_d   = state_q;
      i_d       = i_q;
      k_d       = k_q;
      rj_d      = rj_q;
      k_req_d   = k_req_q;
      j_req_d   = j_req_q;
      k_write_d = k_write_q;
      f_data_d  = f_data_q;
      b_data_d  = b_data_q;
      ov_d      = 1'b0;
      done_d    = 1'b0;
      busy_d    = busy_q;
      go_row    = 1'b0;
      kn        = k_q;
      vld_d     = vld_q << 1;
      last_d    = last_q << 1;

      // strict compare keeps the earliest j on ties
      min_n = min_q;
      arg_n = arg_q;
      if (resp) begin
         rj_d = rj_q + 1'b1;
         if (sum_sat < min_q) begin
            min_n = sum_sat;
            arg_n = rj_q;
         end
      end
      min_d = min_n;
      arg_d = arg_n;

      unique case (state_q)
         IDLE: begin
            if (begin_iter) begin
               i_d       = i;
               busy_d    = 1'b1;
               state_d   = ROW0;
               ov_d      = 1'b1;
               k_write_d = '0;
               f_data_d  = e_head;
               b_data_d  = '0;
            end
         end
         ROW0: begin
            if (FORMANTS == 1) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               go_row = 1'b1;
               kn     = KW'(1);
            end
         end
         ISSUE: begin
            vld_d[0]  = 1'b1;
            last_d[0] = (j_req_q == i_q);
            if (j_req_q == i_q) state_d = DRAIN;
            else j_req_d = j_req_q + 1'b1;
         end
         DRAIN: begin
            if (resp && last_q[READ_LAT-1]) begin
               state_d   = WRITE;
               ov_d      = 1'b1;
               k_write_d = k_q;
               f_data_d  = min_n;
               b_data_d  = arg_n;
            end
         end
         WRITE: begin
            if (k_q == KW'(FORMANTS - 1)) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               go_row = 1'b1;
               kn     = k_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase

      // infeasible rows (i < k) skip the read phase entirely
      if (go_row) begin
         k_d = kn;
         if (i_q < I_WIDTH'(kn)) begin
            state_d   = WRITE;
            ov_d      = 1'b1;
            k_write_d = kn;
            f_data_d  = '1;
            b_data_d  = '0;
         end else begin
            state_d = ISSUE;
            k_req_d = kn;
            j_req_d = I_WIDTH'(kn) - 1'b1;
            min_d   = '1;
            arg_d   = I_WIDTH'(kn) - 1'b1;
            rj_d    = I_WIDTH'(kn) - 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q   <= IDLE;
         i_q       <= '0;
         k_q       <= '0;
         min_q     <= '0;
         arg_q     <= '0;
         rj_q      <= '0;
         vld_q     <= '0;
         last_q    <= '0;
         k_req_q   <= '0;
         j_req_q   <= '0;
         k_write_q <= '0;
         f_data_q  <= '0;
         b_data_q  <= '0;
         ov_q      <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         i_q       <= i_d;
         k_q       <= k_d;
         min_q     <= min_d;
         arg_q     <= arg_d;
         rj_q      <= rj_d;
         vld_q     <= vld_d;
         last_q    <= last_d;
         k_req_q   <= k_req_d;
         j_req_q   <= j_req_d;
         k_write_q <= k_write_d;
         f_data_q  <= f_data_d;
         b_data_q  <= b_data_d;
         ov_q      <= ov_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
      end
   end

   assign k_req        = k_req_q;
   assign j_req        = j_req_q;
   assign k_write      = k_write_q;
   assign f_data       = f_data_q;
   assign b_data       = b_data_q;
   assign output_valid = ov_q;
   assign iter_done    = done_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_formant_dp_sched.sv
// Directed bench for formant_dp_sched: BRAM model with 2-cycle latency,
// write/done monitor and hand-computed expected write schedules.
module tb_formant_dp_sched;

   logic        clk = 1'b0;
   logic        rst_in;
   logic        begin_iter;
   logic [7:0]  i;
   logic [31:0] e_head;
   logic [31:0] e_prev;
   logic [31:0] f_prev;
   logic [1:0]  k_req;
   logic [7:0]  j_req;
   logic [1:0]  k_write;
   logic [31:0] f_data;
   logic [7:0]  b_data;
   logic        output_valid;
   logic        iter_done;
   logic        busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int base     = 0;
   int done_cyc = -1;
   int overlap  = 0;
   logic [7:0] jr [0:63];
   logic sat_mode = 1'b0;

   typedef struct {
      int          c;
      int          k;
      logic [31:0] f;
      logic [7:0]  b;
   } wr_t;
   wr_t wq[$];

   formant_dp_sched #(
      .BIT_WIDTH(32), .I(160), .FORMANTS(4), .READ_LAT(2)
   ) dut (
      .clk_in(clk), .rst_in(rst_in), .begin_iter(begin_iter),
      .i(i), .e_head(e_head), .e_prev(e_prev), .f_prev(f_prev),
      .k_req(k_req), .j_req(j_req), .k_write(k_write),
      .f_data(f_data), .b_data(b_data), .output_valid(output_valid),
      .iter_done(iter_done), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // BRAM model: address registered twice, data valid 2 cycles after request
   logic [1:0] p1k, p2k;
   logic [7:0] p1j, p2j;
   always @(posedge clk) begin
      p1k <= k_req;
      p1j <= j_req;
      p2k <= p1k;
      p2j <= p1j;
   end

   function automatic logic [31:0] sum_tbl(input logic [1:0] k,
                                           input logic [7:0] j);
      if (k == 2'd1 && j == 8'd0) return 32'd10;
      if (k == 2'd1 && j == 8'd1) return 32'd4;
      if (k == 2'd1 && j == 8'd2) return 32'd4;
      if (k == 2'd2 && j == 8'd1) return 32'd9;
      if (k == 2'd2 && j == 8'd2) return 32'd6;
      return 32'd100;
   endfunction

   assign f_prev = sat_mode ? 32'hFFFF_FFFF : sum_tbl(p2k, p2j) - 32'd3;
   assign e_prev = sat_mode ? 32'd5 : 32'd3;

   always @(negedge clk) begin
      if (output_valid)
         wq.push_back('{cyc - base, int'(k_write), f_data, b_data});
      if (iter_done) done_cyc = cyc - base;
      if (output_valid && iter_done) overlap++;
      if (cyc - base >= 0 && cyc - base < 64) jr[cyc - base] = j_req;
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_wr(input string tag, input int n, input int c,
                         input int k, input logic [31:0] f,
                         input logic [7:0] b);
      if (n >= wq.size()) begin
         checks++;
         failures++;
         $error("FAIL %s write %0d missing obs=%0d exp=%0d",
                tag, n, wq.size(), n + 1);
      end else begin
         chk({tag, "_cyc"}, 64'(wq[n].c), 64'(c));
         chk({tag, "_k"}, 64'(wq[n].k), 64'(k));
         chk({tag, "_f"}, 64'(wq[n].f), 64'(f));
         chk({tag, "_b"}, 64'(wq[n].b), 64'(b));
      end
   endtask

   task automatic start(input logic [7:0] ii, input logic [31:0] eh);
      @(negedge clk);
      i          = ii;
      e_head     = eh;
      begin_iter = 1'b1;
      base       = cyc;
      wq.delete();
      done_cyc   = -1;
      @(negedge clk);
      begin_iter = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int exp);
      int n;
      n = 0;
      while (done_cyc < 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      @(negedge clk);
      chk({tag, "_done"}, 64'(done_cyc), 64'(exp));
      chk({tag, "_idle"}, 64'(busy), 64'd0);
   endtask

   task automatic chk_outs_zero(input string tag);
      chk(tag, 64'({k_req, j_req, k_write, f_data, b_data,
                    output_valid, iter_done, busy}), 64'd0);
   endtask

   task automatic chk_i2(input string tag);
      chk(tag, 64'(wq.size()), 64'd4);
      chk_wr(tag, 0, 1, 0, 32'd20, 8'd0);
      chk_wr(tag, 1, 7, 1, 32'd4, 8'd1);
      chk_wr(tag, 2, 12, 2, 32'd6, 8'd2);
      chk_wr(tag, 3, 13, 3, 32'hFFFF_FFFF, 8'd0);
   endtask

   initial begin
      rst_in     = 1'b1;
      begin_iter = 1'b0;
      i          = '0;
      e_head     = '0;
      #3;
      chk_outs_zero("rst_init");
      begin_iter = 1'b1;
      i          = 8'd3;
      repeat (3) @(negedge clk);
      begin_iter = 1'b0;
      chk_outs_zero("rst_begin");
      rst_in = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_nobusy", 64'(busy), 64'd0);

      // i=0: every row k>0 infeasible, back-to-back writes
      start(8'd0, 32'd7);
      chk("i0_busy", 64'(busy), 64'd1);
      wait_done("i0", 5);
      chk("i0_cnt", 64'(wq.size()), 64'd4);
      chk_wr("i0", 0, 1, 0, 32'd7, 8'd0);
      chk_wr("i0", 1, 2, 1, 32'hFFFF_FFFF, 8'd0);
      chk_wr("i0", 2, 3, 2, 32'hFFFF_FFFF, 8'd0);
      chk_wr("i0", 3, 4, 3, 32'hFFFF_FFFF, 8'd0);

      // i=2: reads, tie on k=1, late minimum on k=2
      start(8'd2, 32'd20);
      wait_done("i2", 14);
      chk_i2("i2");
      chk("i2_j2", 64'(jr[2]), 64'd0);
      chk("i2_j3", 64'(jr[3]), 64'd1);
      chk("i2_j4", 64'(jr[4]), 64'd2);
      chk("i2_j8", 64'(jr[8]), 64'd1);
      chk("i2_j9", 64'(jr[9]), 64'd2);

      // begin_iter re-pulsed at cycle 3 must be ignored
      start(8'd2, 32'd20);
      @(negedge clk);
      @(negedge clk);
      i          = 8'd5;
      e_head     = 32'd99;
      begin_iter = 1'b1;
      @(negedge clk);
      begin_iter = 1'b0;
      wait_done("rep", 14);
      chk_i2("rep");

      // saturation: every sum overflows, argmin stays k-1
      sat_mode = 1'b1;
      start(8'd2, 32'd1);
      wait_done("sat", 14);
      chk("sat_cnt", 64'(wq.size()), 64'd4);
      chk_wr("sat", 1, 7, 1, 32'hFFFF_FFFF, 8'd0);
      chk_wr("sat", 2, 12, 2, 32'hFFFF_FFFF, 8'd1);
      sat_mode = 1'b0;

      // async reset during DRAIN of row 1
      start(8'd2, 32'd20);
      repeat (4) @(negedge clk);
      chk("drn_busy", 64'(busy), 64'd1);
      chk("drn_kreq", 64'(k_req), 64'd1);
      #1 rst_in = 1'b1;
      #1 chk_outs_zero("drn_rst");
      repeat (2) @(negedge clk);
      rst_in = 1'b0;
      wq.delete();
      done_cyc = -1;
      repeat (20) @(negedge clk);
      chk("drn_nowr", 64'(wq.size()), 64'd0);
      chk("drn_nodone", 64'(done_cyc), 64'hFFFF_FFFF_FFFF_FFFF);

      start(8'd2, 32'd20);
      wait_done("post", 14);
      chk_i2("post");

      chk("no_overlap", 64'(overlap), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
